uart_transmitter: RTL

//  Serialises bytes onto the UART tx line (8N1, LSB first); peer of the uart_receiver path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_transmitter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit path.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    // Transmit FSM states; PARITY only exists in parity-enabled builds.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP  = 3'd4
    } tx_state_t;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with show-ahead output (dout is always the head entry).
// full/empty/count come only from registered state, so a pop in the same cycle
// never frees room for a simultaneous write.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             din,
    input  logic                     rd_en,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, one stop bit, driven by a 16x
// oversample enable shared with the receiver. A small FIFO buffers bytes
// from the bus; back-to-back frames leave no idle gap on the line.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic                          clken,
    input  logic [UART_DATA_W-1:0]        din,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    tx_state_t               state_q;
    logic [TICK_W-1:0]       tick_q;
    logic [2:0]              bitpos_q;
    logic [UART_DATA_W-1:0]  shift_q;
    logic                    tx_q;
    logic                    busy_q;
    logic                    overflow_q;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [UART_DATA_W-1:0]  fifo_dout;
    logic                    fifo_rd;
    logic                    bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .din     (din),
        .rd_en   (fifo_rd),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Last oversample tick of the current bit.
    assign bit_end = clken && (tick_q == TICK_LAST);

    // A byte leaves the FIFO when the line is idle or exactly as a stop bit ends.
    assign fifo_rd = clken && !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // Frame sequencer: every move waits for clken; tx is driven from a register.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bitpos_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (clken) begin
            if (state_q != IDLE) begin
                tick_q <= bit_end ? '0 : tick_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_rd) begin
                        shift_q <= fifo_dout;
                        tx_q    <= 1'b0;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= uart_parity(fifo_dout);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q     <= shift_q[0];
                        bitpos_q <= '0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bitpos_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                            bitpos_q <= bitpos_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (fifo_rd) begin
                            shift_q <= fifo_dout;
                            tx_q    <= 1'b0;
                            tick_q  <= '0;
                            state_q <= START;
`ifdef UART_TX_PARITY_EN
                            parity_q <= uart_parity(fifo_dout);
`endif
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One-cycle flag for a write that arrived while the FIFO was already full.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && fifo_full;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign full     = fifo_full;

endmodule
